cnn_tile_sequencer: RTL

- Parametrised next-generation CNN control FSM.
- Sequences a layer as cfg_num_tiles output tiles × cfg_num_ch input channels: per channel, memory load then one MAC pass; per tile, writeback after the last channel.
- Adds runtime configuration, channel/tile indices, an accumulator-clear pulse, single-cycle MAC start, abort, and a handshake watchdog with sticky error.
- Sits between the accelerator command interface and the MAC/memory/FIFO datapath.

---
 rtl/cnn_ctrl_pkg.sv | 29 ++
 rtl/cnn_watchdog.sv | 44 ++++
 rtl/cnn_tile_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cnn_ctrl_pkg : state encoding and default sizing for the CNN tile sequencer
// Revision     : 1.0
// ============================================================================
package cnn_ctrl_pkg;

  localparam int DEF_CH_W    = 4;
  localparam int DEF_TILE_W  = 8;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_TO_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_WAIT_MAC  = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FINISH    = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  // States that block on an external handshake and are policed by the watchdog
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_LOAD) || (s == ST_WAIT_MAC) || (s == ST_WRITEBACK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_watchdog.sv
`default_nettype none
// ============================================================================
// cnn_watchdog : counts consecutive cycles without a handshake; expire fires
//                in the TIMEOUT-th such cycle
// Revision     : 1.0
// ============================================================================
module cnn_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] C_LIMIT = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] C_ONE   = TO_W'(1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  assign expire = enable && (cnt_q == C_LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cnn_tile_sequencer.sv
`default_nettype none
// ============================================================================
// cnn_tile_sequencer : per-layer LOAD/MAC/WRITEBACK sequencing over tiles and
//                      input channels, with abort and handshake watchdog
// Revision           : 1.0
// ============================================================================
module cnn_tile_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int CH_W    = DEF_CH_W,
  parameter int TILE_W  = DEF_TILE_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              mem_ready,
  input  logic              mac_done,
  input  logic              fifo_empty,
  output logic              mem_read,
  output logic              mac_start,
  output logic              mac_clear,
  output logic              mem_write,
  output logic [CH_W-1:0]   ch_idx,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  localparam logic [CH_W-1:0]   C_CH_ONE   = CH_W'(1);
  localparam logic [TILE_W-1:0] C_TILE_ONE = TILE_W'(1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
  logic [TILE_W-1:0]   tile_idx_q, tile_idx_d;
  logic [CH_W-1:0]     num_ch_q, num_ch_d;
  logic [TILE_W-1:0]   num_tiles_q, num_tiles_d;
  logic                timeout_err_q, timeout_err_d;
  logic                mem_read_q, mem_read_d;
  logic                mac_start_q, mac_start_d;
  logic                mac_clear_q, mac_clear_d;
  logic                mem_write_q, mem_write_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic wd_hs;
  logic wd_enable;
  logic wd_clear;
  logic wd_expire;

  always_comb begin
    wd_hs = 1'b0;
    case (state_q)
      ST_LOAD:      wd_hs = mem_ready;
      ST_WAIT_MAC:  wd_hs = mac_done;
      ST_WRITEBACK: wd_hs = fifo_empty;
      default:      wd_hs = 1'b0;
    endcase
  end

  assign wd_enable = is_wait_state(state_q) && !wd_hs;

  cnn_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    tile_idx_d    = tile_idx_q;
    num_ch_d      = num_ch_q;
    num_tiles_d   = num_tiles_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          timeout_err_d = 1'b0;
          if ((cfg_num_ch != '0) && (cfg_num_tiles != '0)) begin
            state_d     = ST_LOAD;
            num_ch_d    = cfg_num_ch;
            num_tiles_d = cfg_num_tiles;
            ch_idx_d    = '0;
            tile_idx_d  = '0;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LOAD: begin
        if (wd_expire) begin
          state_d = ST_ERROR;
        end else if (mem_ready) begin
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        state_d = ST_WAIT_MAC;
      end
      ST_WAIT_MAC: begin
        if (wd_expire) begin
          state_d = ST_ERROR;
        end else if (mac_done) begin
          if (ch_idx_q == (num_ch_q - C_CH_ONE)) begin
            state_d = ST_WRITEBACK;
          end else begin
            ch_idx_d = ch_idx_q + C_CH_ONE;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_WRITEBACK: begin
        if (wd_expire) begin
          state_d = ST_ERROR;
        end else if (fifo_empty) begin
          if (tile_idx_q == (num_tiles_q - C_TILE_ONE)) begin
            state_d = ST_FINISH;
          end else begin
            tile_idx_d = tile_idx_q + C_TILE_ONE;
            ch_idx_d   = '0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Abort outranks both the watchdog and any handshake seen this cycle
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      ch_idx_d   = ch_idx_q;
      tile_idx_d = tile_idx_q;
    end

    if (state_d == ST_ERROR) begin
      timeout_err_d = 1'b1;
    end

    // Every entry into a wait state comes from a different state
    wd_clear = (state_d != state_q);

    mem_read_d  = (state_d == ST_LOAD);
    mac_start_d = (state_d == ST_COMPUTE);
    mac_clear_d = (state_d == ST_COMPUTE) && (ch_idx_d == '0);
    mem_write_d = (state_d == ST_WRITEBACK);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ch_idx_q      <= '0;
      tile_idx_q    <= '0;
      num_ch_q      <= '0;
      num_tiles_q   <= '0;
      timeout_err_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mac_start_q   <= 1'b0;
      mac_clear_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      tile_idx_q    <= tile_idx_d;
      num_ch_q      <= num_ch_d;
      num_tiles_q   <= num_tiles_d;
      timeout_err_q <= timeout_err_d;
      mem_read_q    <= mem_read_d;
      mac_start_q   <= mac_start_d;
      mac_clear_q   <= mac_clear_d;
      mem_write_q   <= mem_write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mac_start   = mac_start_q;
  assign mac_clear   = mac_clear_q;
  assign mem_write   = mem_write_q;
  assign ch_idx      = ch_idx_q;
  assign tile_idx    = tile_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire
